// File: rtl/mux_ser_pkg.sv
// Shared widths and FSM state encoding for the mux_ser_seq serializer.
// MUX_SER_PARITY_EN adds the ST_PAR state and the parity helper.
package mux_ser_pkg;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

`ifdef MUX_SER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif
endpackage

// File: rtl/mux8_1.sv
// 8:1 bit mux selecting d[sel]; purely combinational, no backpressure.
module mux8_1
    import mux_ser_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    input  logic [SEL_W-1:0]  sel,
    output logic              y
);
    assign y = d[sel];
endmodule

// File: rtl/mux_ser_seq.sv
// LSB-first serializer holding each bit BIT_CYCLES clocks; frame = 8*BIT_CYCLES (+1 bit with MUX_SER_PARITY_EN).
// in_ready only in IDLE, so a word is taken one cycle after the previous frame ends; mid-frame in_valid is ignored.
module mux_ser_seq
    import mux_ser_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] d_out,
    output logic [SEL_W-1:0]  sel_out,
    output logic              ser_out,
    output logic              bit_strobe,
    output logic              busy,
    output logic              frame_done
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(BIT_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DATA_W - 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [DATA_W-1:0] d_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic              strobe_nxt, done_nxt;
    logic              last_cyc;
    logic              mux_bit;

    mux8_1 u_mux (
        .d   (d_out),
        .sel (sel_out),
        .y   (mux_bit)
    );

    assign last_cyc = (cnt == LAST_CNT);
    assign in_ready = (state == ST_IDLE);
    assign busy     = ~in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            d_out      <= '0;
            sel_out    <= '0;
            bit_strobe <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            d_out      <= d_nxt;
            sel_out    <= sel_nxt;
            bit_strobe <= strobe_nxt;
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        d_nxt      = d_out;
        sel_nxt    = sel_out;
        strobe_nxt = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    d_nxt      = in_data;
                    sel_nxt    = '0;
                    cnt_nxt    = '0;
                    strobe_nxt = 1'b1;
                    state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!last_cyc) begin
                    cnt_nxt = cnt + CW'(1);
                end else begin
                    cnt_nxt = '0;
                    // sel_out stays at 7 on exit so d_out/sel_out hold their final values
                    if (sel_out == LAST_SEL) begin
`ifdef MUX_SER_PARITY_EN
                        state_nxt  = ST_PAR;
                        strobe_nxt = 1'b1;
`else
                        state_nxt  = ST_IDLE;
                        done_nxt   = 1'b1;
`endif
                    end else begin
                        sel_nxt    = sel_out + SEL_W'(1);
                        strobe_nxt = 1'b1;
                    end
                end
            end
`ifdef MUX_SER_PARITY_EN
            ST_PAR: begin
                if (!last_cyc) begin
                    cnt_nxt = cnt + CW'(1);
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ser_out = 1'b0;
        case (state)
            ST_SHIFT: ser_out = mux_bit;
`ifdef MUX_SER_PARITY_EN
            ST_PAR:   ser_out = even_parity(d_out);
`endif
            default:  ser_out = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_mux_ser_seq.sv
// Directed bench for mux_ser_seq with BIT_CYCLES=1 and BIT_CYCLES=3 instances.
module tb_mux_ser_seq;
`ifdef MUX_SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, v1, rdy1, ser1, stb1, busy1, done1;
    logic [7:0] d1, dout1;
    logic [2:0] sel1;
    logic       rst3, v3, rdy3, ser3, stb3, busy3, done3;
    logic [7:0] d3, dout3;
    logic [2:0] sel3;

    int n_cmp = 0;
    int n_err = 0;

    mux_ser_seq #(.BIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst1), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
        .d_out(dout1), .sel_out(sel1), .ser_out(ser1), .bit_strobe(stb1),
        .busy(busy1), .frame_done(done1)
    );

    mux_ser_seq #(.BIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst3), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
        .d_out(dout3), .sel_out(sel3), .ser_out(ser3), .bit_strobe(stb3),
        .busy(busy3), .frame_done(done3)
    );

    // Reference model: bit i of the frame (index 8 is the parity bit)
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        return (i > 7) ? ^d : d[i];
    endfunction

    function automatic logic [2:0] exp_sel(input int i);
        return (i > 7) ? 3'd7 : 3'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst3 = 1'b1; v1 = 1'b1; v3 = 1'b1; d1 = 8'hFF; d3 = 8'hFF;
        tick(); tick();
        rst1 = 1'b0; rst3 = 1'b0; v1 = 1'b0; v3 = 1'b0;
        n_cmp++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL reset_rdy1 got %b want 1", rdy1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy1 got %b want 0", busy1); end
        n_cmp++; if (dout1 !== 8'h00) begin n_err++; $display("FAIL reset_dout1 got %h want 00", dout1); end
        n_cmp++; if (sel1 !== 3'd0) begin n_err++; $display("FAIL reset_sel1 got %0d want 0", sel1); end
        n_cmp++; if ({ser1, stb1, done1} !== 3'b000) begin n_err++; $display("FAIL reset_outs1 got %b want 000", {ser1, stb1, done1}); end
        n_cmp++; if ({rdy3, busy3, dout3, sel3, ser3, stb3, done3} !== {1'b1, 1'b0, 8'h00, 3'd0, 3'b000})
            begin n_err++; $display("FAIL reset_dut3 got %b/%b/%h/%0d/%b%b%b", rdy3, busy3, dout3, sel3, ser3, stb3, done3); end
    endtask

    task automatic test_basic_a5();
        logic [7:0] w = 8'hA5;
        v1 = 1'b1; d1 = w;
        tick();
        v1 = 1'b0; d1 = 8'h00;
        for (int i = 0; i < NB; i++) begin
            n_cmp++; if (sel1 !== exp_sel(i)) begin n_err++; $display("FAIL a5_sel[%0d] got %0d want %0d", i, sel1, exp_sel(i)); end
            n_cmp++; if (ser1 !== exp_bit(w, i)) begin n_err++; $display("FAIL a5_ser[%0d] got %b want %b", i, ser1, exp_bit(w, i)); end
            n_cmp++; if ({stb1, busy1, done1} !== 3'b110) begin n_err++; $display("FAIL a5_ctl[%0d] got %b want 110", i, {stb1, busy1, done1}); end
            tick();
        end
        n_cmp++; if ({done1, rdy1, ser1} !== 3'b110) begin n_err++; $display("FAIL a5_done got %b want 110", {done1, rdy1, ser1}); end
        n_cmp++; if ({dout1, sel1} !== {8'hA5, 3'd7}) begin n_err++; $display("FAIL a5_hold got %h/%0d want a5/7", dout1, sel1); end
        tick();
        n_cmp++; if ({done1, stb1} !== 2'b00) begin n_err++; $display("FAIL a5_done_pulse got %b want 00", {done1, stb1}); end
    endtask

    task automatic test_bit_cycles3();
        logic [7:0] w = 8'h0F;
        v3 = 1'b1; d3 = w;
        tick();
        v3 = 1'b0;
        for (int c = 0; c < NB * 3; c++) begin
            n_cmp++; if (sel3 !== exp_sel(c / 3)) begin n_err++; $display("FAIL bc3_sel[%0d] got %0d want %0d", c, sel3, exp_sel(c / 3)); end
            n_cmp++; if (ser3 !== exp_bit(w, c / 3)) begin n_err++; $display("FAIL bc3_ser[%0d] got %b want %b", c, ser3, exp_bit(w, c / 3)); end
            n_cmp++; if (stb3 !== ((c % 3) == 0)) begin n_err++; $display("FAIL bc3_stb[%0d] got %b want %b", c, stb3, (c % 3) == 0); end
            n_cmp++; if ({busy3, done3} !== 2'b10) begin n_err++; $display("FAIL bc3_ctl[%0d] got %b want 10", c, {busy3, done3}); end
            tick();
        end
        n_cmp++; if ({done3, rdy3, stb3} !== 3'b110) begin n_err++; $display("FAIL bc3_done got %b want 110", {done3, rdy3, stb3}); end
        tick();
        n_cmp++; if (done3 !== 1'b0) begin n_err++; $display("FAIL bc3_done_pulse got %b want 0", done3); end
    endtask

    task automatic test_back_to_back();
        v1 = 1'b1; d1 = 8'h01;
        tick();
        d1 = 8'h80;
        for (int i = 0; i < NB; i++) begin
            n_cmp++; if (ser1 !== exp_bit(8'h01, i)) begin n_err++; $display("FAIL b2b_w0_ser[%0d] got %b want %b", i, ser1, exp_bit(8'h01, i)); end
            n_cmp++; if (dout1 !== 8'h01) begin n_err++; $display("FAIL b2b_w0_dout[%0d] got %h want 01", i, dout1); end
            tick();
        end
        n_cmp++; if ({done1, rdy1} !== 2'b11) begin n_err++; $display("FAIL b2b_gap got %b want 11", {done1, rdy1}); end
        tick();
        v1 = 1'b0;
        for (int i = 0; i < NB; i++) begin
            n_cmp++; if (ser1 !== exp_bit(8'h80, i)) begin n_err++; $display("FAIL b2b_w1_ser[%0d] got %b want %b", i, ser1, exp_bit(8'h80, i)); end
            n_cmp++; if ({dout1, sel1, stb1} !== {8'h80, exp_sel(i), i == 0 || i < 9})
                begin n_err++; $display("FAIL b2b_w1_st[%0d] got %h/%0d/%b", i, dout1, sel1, stb1); end
            tick();
        end
        n_cmp++; if ({done1, rdy1} !== 2'b11) begin n_err++; $display("FAIL b2b_w1_done got %b want 11", {done1, rdy1}); end
        tick();
        n_cmp++; if ({done1, busy1} !== 2'b00) begin n_err++; $display("FAIL b2b_no_dup got %b want 00", {done1, busy1}); end
    endtask

    task automatic test_rst_mid_frame();
        logic saw_done = 1'b0;
        v1 = 1'b1; d1 = 8'hFF;
        tick();
        v1 = 1'b0;
        repeat (4) tick();
        n_cmp++; if (sel1 !== 3'd4) begin n_err++; $display("FAIL rst_pre_sel got %0d want 4", sel1); end
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        n_cmp++; if ({rdy1, busy1, ser1, stb1, done1} !== 5'b10000) begin n_err++; $display("FAIL rst_ctl got %b want 10000", {rdy1, busy1, ser1, stb1, done1}); end
        n_cmp++; if ({dout1, sel1} !== {8'h00, 3'd0}) begin n_err++; $display("FAIL rst_regs got %h/%0d want 00/0", dout1, sel1); end
        for (int i = 0; i < 12; i++) begin
            saw_done = saw_done | done1;
            tick();
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL rst_no_done got %b want 0", saw_done); end
        rst1 = 1'b1; v1 = 1'b1; d1 = 8'h5A;
        tick();
        rst1 = 1'b0; v1 = 1'b0;
        n_cmp++; if ({rdy1, dout1} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL rst_priority got %b/%h want 1/00", rdy1, dout1); end
    endtask

    task automatic test_mid_frame_ignore();
        logic [7:0] w = 8'h3C;
        v1 = 1'b1; d1 = w;
        tick();
        for (int i = 0; i < NB; i++) begin
            v1 = i[0];
            d1 = ~d1 ^ 8'(i * 37);
            n_cmp++; if (dout1 !== w) begin n_err++; $display("FAIL ign_dout[%0d] got %h want 3c", i, dout1); end
            n_cmp++; if (ser1 !== exp_bit(w, i)) begin n_err++; $display("FAIL ign_ser[%0d] got %b want %b", i, ser1, exp_bit(w, i)); end
            tick();
        end
        v1 = 1'b0;
        n_cmp++; if ({done1, dout1} !== {1'b1, 8'h3C}) begin n_err++; $display("FAIL ign_done got %b/%h want 1/3c", done1, dout1); end
        tick();
    endtask

`ifdef MUX_SER_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [2] = '{8'h07, 8'h03};
        logic       par   [2] = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            v1 = 1'b1; d1 = words[k];
            tick();
            v1 = 1'b0;
            repeat (8) tick();
            n_cmp++; if ({ser1, sel1, stb1} !== {par[k], 3'd7, 1'b1})
                begin n_err++; $display("FAIL par_%h got %b/%0d/%b want %b/7/1", words[k], ser1, sel1, stb1, par[k]); end
            tick();
            n_cmp++; if (done1 !== 1'b1) begin n_err++; $display("FAIL par_done_%h got %b want 1", words[k], done1); end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_a5();
        test_bit_cycles3();
        test_back_to_back();
        test_rst_mid_frame();
        test_mid_frame_ignore();
`ifdef MUX_SER_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux_ser_seq.md
MUX_SER_SEQ -- requirements
Module: mux_ser_seq

Interface
REQ-001 Parameter BIT_CYCLES, default 1; clocks each bit is held (legal range 1..255).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_data  input  8  parallel word to serialize.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 d_out  output  8  latched word, drives mux8_1 d.
REQ-008 sel_out  output  3  current bit index, drives mux8_1 sel.
REQ-009 ser_out  output  1  current serial bit.
REQ-010 bit_strobe  output  1  high on first cycle of each bit period.
REQ-011 busy  output  1  frame in progress.
REQ-012 frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-013 States: IDLE, SHIFT, PAR (PAR exists only with PARITY_EN).
REQ-014 in_ready SHALL equal (state==IDLE); busy SHALL equal its inverse.
REQ-015 Accept = in_valid && in_ready at a rising edge: d_out<=in_data, sel_out<=0, cycle counter<=0, state<=SHIFT.
REQ-016 in_valid while not ready SHALL be ignored; in_data changes mid-frame SHALL not affect d_out.
REQ-017 In SHIFT each sel_out value SHALL be held exactly BIT_CYCLES cycles, sequence 0,1,...,7 (LSB first).
REQ-018 ser_out SHALL equal d_out[sel_out] in SHIFT, parity bit in PAR, 0 in IDLE.
REQ-019 bit_strobe SHALL be high on the cycle after accept and on the first cycle of every subsequent bit period; low in IDLE.
REQ-020 After last cycle of sel_out=7: go to PAR if PARITY_EN, else IDLE; sel_out SHALL not wrap to 0 before leaving SHIFT.
REQ-021 frame_done SHALL pulse for one cycle, the first cycle in IDLE after a completed frame; in_ready SHALL be high that same cycle, allowing back-to-back accept.
REQ-022 Frame length SHALL be 8*BIT_CYCLES cycles (9*BIT_CYCLES with PARITY_EN); back-to-back throughput one word per frame length + 1 cycles.
REQ-023 BIT_CYCLES=1 SHALL work with no idle cycles inside the frame; counter width SHALL be $clog2(BIT_CYCLES) with a 1-bit minimum.
REQ-024 d_out and sel_out SHALL hold their last values in IDLE.

Reset
REQ-025 rst high at an edge SHALL set state=IDLE, d_out=0, sel_out=0, counter=0, bit_strobe=0, frame_done=0; ser_out=0 and in_ready=1 thereafter.
REQ-026 rst mid-frame SHALL abort the frame with no frame_done pulse; rst has priority over accept.

Configuration
REQ-027 Macro MUX_SER_PARITY_EN defined: PAR state appended, one bit period with ser_out = even parity (XOR of d_out), sel_out held at 7, bit_strobe on its first cycle.
REQ-028 Macro undefined: no PAR state, no parity logic; SHIFT returns directly to IDLE.

Structure
REQ-029 Package mux_ser_pkg SHALL hold DATA_W=8, SEL_W=3 and the state encoding constants.
REQ-030 ser_out in SHIFT SHALL come from one instantiated mux8_1 sub-module (d=d_out, sel=sel_out), gated by state.

Verification
REQ-031 BIT_CYCLES=1, accept 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles, sel_out 0..7, frame_done one cycle later.
REQ-032 BIT_CYCLES=3, accept 8'h0F -> each bit held 3 cycles, bit_strobe every 3rd cycle, 24-cycle frame.
REQ-033 in_valid held high with 8'h01 then 8'h80 -> second accept on frame_done cycle, no lost or duplicated word.
REQ-034 rst asserted at sel_out=4 -> next cycle IDLE, d_out=0, no frame_done, in_ready=1.
REQ-035 MUX_SER_PARITY_EN, accept 8'h07 -> 9th bit ser_out=1; 8'h03 -> 9th bit 0.
REQ-036 in_data toggled and in_valid pulsed mid-frame -> d_out and serial sequence unchanged.
